// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-lights blocks: reaction-timer states and
// the two lights-bus values the timer keys off.
package f1_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      TIMING,
      DONE,
      FAULT
   } state_t;

   localparam logic [7:0] LIGHTS_OFF    = 8'h00;
   localparam logic [7:0] LIGHTS_ALL_ON = 8'hFF;

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk down to a one-cycle millisecond tick; clear restarts the phase
// so the first tick lands exactly TICK_DIV enabled cycles after clear drops.
module ms_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

   assign tick = en & ~clear & (cnt == LAST);

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures driver reaction in whole ms from lights-out to button press, with
// jump-start / timeout detection and best-time tracking since reset.
module f1_reaction_timer
   import f1_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT_MS = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       lights,
   input  logic             button,
   output logic [CNT_W-1:0] time_ms,
   output logic [CNT_W-1:0] best_ms,
   output logic             result_valid,
   output logic             jump_start,
   output logic             timeout,
   output logic             busy
);

   state_t           state;
   logic             button_q;
   logic             all_on;
   logic             press;
   logic             tick;
   logic [CNT_W-1:0] ms_cnt;
   logic [CNT_W-1:0] count;

   assign press = button & ~button_q;
   // Include a tick landing on this edge, so a press exactly k*TICK_DIV
   // cycles after lights-out reports k rather than k-1.
   assign count = ms_cnt + CNT_W'(tick);

   ms_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clear(state != TIMING),
      .en   (state == TIMING),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         time_ms      <= '0;
         best_ms      <= '1;
         result_valid <= 1'b0;
         jump_start   <= 1'b0;
         timeout      <= 1'b0;
         busy         <= 1'b0;
         all_on       <= 1'b0;
         ms_cnt       <= '0;
         button_q     <= 1'b1;
      end else begin
         button_q     <= button;
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (lights != LIGHTS_OFF) begin
                  state      <= ARMED;
                  busy       <= 1'b1;
                  jump_start <= 1'b0;
                  timeout    <= 1'b0;
                  all_on     <= 1'b0;
               end
            end
            ARMED: begin
               if (lights == LIGHTS_ALL_ON) all_on <= 1'b1;
               if (lights != LIGHTS_OFF) begin
                  if (press) begin
                     state      <= FAULT;
                     busy       <= 1'b0;
                     jump_start <= 1'b1;
                  end
               end else if (!all_on) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (press) begin
                  // press on the very lights-out edge is a legal 0 ms result
                  state        <= DONE;
                  busy         <= 1'b0;
                  time_ms      <= '0;
                  best_ms      <= '0;
                  result_valid <= 1'b1;
               end else begin
                  state  <= TIMING;
                  ms_cnt <= '0;
               end
            end
            TIMING: begin
               ms_cnt <= count;
               if (press) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  time_ms      <= count;
                  result_valid <= 1'b1;
                  if (count < best_ms) best_ms <= count;
               end else if (count == CNT_W'(TIMEOUT_MS)) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  time_ms      <= count;
                  timeout      <= 1'b1;
                  result_valid <= 1'b1;
               end
            end
            DONE: begin
               if (lights != LIGHTS_OFF) begin
                  state      <= ARMED;
                  busy       <= 1'b1;
                  jump_start <= 1'b0;
                  timeout    <= 1'b0;
                  all_on     <= 1'b0;
               end
            end
            FAULT: begin
               if (lights == LIGHTS_OFF) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
Consumer end of the F1 start-lights sequence: watches the 8-bit lights bus driven by the lights FSM and the driver's button. It measures the reaction time in milliseconds from lights-out (all-on to all-off) to the button press. It flags jump starts and timeouts, and keeps the best time since reset, for the display/readout logic.

Parameters:
TICK_DIV, 1000, clk cycles per millisecond tick (must be >= 2)
CNT_W, 16, width of time_ms/best_ms
TIMEOUT_MS, 9999, reaction count at which a run ends as timeout (< 2^CNT_W - 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
lights  input  8  lights bus from the start-lights FSM (0 = off, 8'hFF = all on)
button  input  1  driver button, already synchronised to clk, active-high
time_ms  output  CNT_W  last result in ms; holds until next result
best_ms  output  CNT_W  minimum valid time since reset; all-ones = none yet
result_valid  output  1  one-cycle pulse when time_ms updates
jump_start  output  1  level, set on jump start, cleared on next arm
timeout  output  1  level, set on timeout, cleared on next arm
busy  output  1  high in ARMED or TIMING

Behaviour:
- Single clock domain; rst low is sampled at posedge clk.
- Reset values:
  - state IDLE; time_ms 0; best_ms all-ones.
  - result_valid, jump_start, timeout, busy all 0.
  - prescaler 0; all_on flag 0; button-edge register 1, so a button held through reset never counts as a press.
- Press definition: press = button & ~button_q. button_q is registered every cycle.
- States and transitions:
  - IDLE:
    - lights != 0 -> ARMED; clear jump_start and timeout; clear all_on.
    - Presses are ignored.
  - ARMED:
    - Set all_on when lights == 8'hFF.
    - Press while lights != 0 -> FAULT; set jump_start.
    - lights == 0 with all_on=1 -> TIMING; clear prescaler and ms counter.
    - lights == 0 with all_on=0 (aborted sequence) -> IDLE, no flags.
    - Press in the same cycle lights become 0 with all_on=1 -> DONE with time_ms=0. This is a valid result and updates best_ms.
  - TIMING:
    - Prescaler counts 0..TICK_DIV-1 and wraps.
    - The ms counter increments on each wrap, so it counts whole ms only.
    - Press -> DONE. time_ms <= count; result_valid pulses.
    - If count < best_ms, best_ms <= count.
    - count == TIMEOUT_MS with no press -> DONE. time_ms <= TIMEOUT_MS; timeout=1; result_valid pulses; best_ms unchanged.
    - Press and timeout in the same cycle: the press wins.
    - lights going non-zero in TIMING is ignored.
  - DONE: outputs hold; lights != 0 -> ARMED (flags cleared; time_ms and best_ms kept).
  - FAULT: jump_start held; lights == 0 -> IDLE (jump_start stays set until next arm).
- Latency and result_valid:
  - A press sampled at edge N produces time_ms/result_valid registered at edge N+1.
  - result_valid is high exactly one cycle and never high in two consecutive cycles.
- Counting arithmetic: a reaction of k*TICK_DIV + r cycles (0 <= r < TICK_DIV) after lights-out reports k.
- Reset mid-run: aborts immediately to reset values, including best_ms.

Decomposition:
- Package f1_pkg:
  - typedef enum for timer states {IDLE, ARMED, TIMING, DONE, FAULT}.
  - Constants LIGHTS_OFF = 8'h00 and LIGHTS_ALL_ON = 8'hFF, shared with the lights FSM.
- One sub-module: ms_prescaler.
  - Parameter TICK_DIV.
  - Inputs clk, rst (active-low sync), clear, en; output tick.
  - tick is one cycle at count TICK_DIV-1.
  - clear has priority over en.

Test Plan:
- All tests use TICK_DIV=4, CNT_W=16, TIMEOUT_MS=10.
- Reset with button held high, then lights 0 and button toggled -> all outputs at reset values, best_ms=16'hFFFF, no result_valid.
- Normal run: lights 01,03,...,FF then 00; press 4*7+2=30 cycles after lights-out -> one result_valid pulse, time_ms=7, best_ms=7, busy falls with the pulse.
- Best tracking: second run with press at 4*3+1 cycles -> time_ms=3, best_ms=3. Third run at 4*9 cycles -> time_ms=9, best_ms stays 3.
- Jump start: press while lights=8'h07 -> jump_start=1, no result_valid, time_ms/best_ms unchanged. Lights to 0 -> IDLE; next lights 01 clears jump_start.
- Timeout: normal sequence, no press -> 40 cycles after lights-out, result_valid pulse, timeout=1, time_ms=10, best_ms unchanged. Press and timeout in the same cycle -> timeout=0, time_ms=10, best_ms updated.
- Edge cases:
  - rst low one cycle during TIMING -> IDLE, best_ms=16'hFFFF.
  - Lights 01..07 then 00 without reaching FF -> IDLE, no result.
  - Press coincident with lights-out -> time_ms=0, result_valid.
